// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - Iterative multiply/divide sequencer owning the HI/LO register pair
//
// Runs MULT/MULTU/DIV/DIVU over multiple cycles on one shared add/subtract
// datapath, serves MFHI/MFLO reads and raises the execute-stage interlock.
// Optional build macro: MULDIV_EARLY_OUT_EN - multiply stops iterating once
// the remaining multiplier bits are zero and realigns the product in FIX.
//
// Ports:
//   clock, reset_n     system clock, asynchronous active-low reset
//   start, aluop, sgn  execute-stage request, decoded op, signed select
//   rA, rB             multiplicand/dividend, multiplier/divisor
//   stall              interlock to the execute stage (combinational)
//   busy               an operation is in flight
//   done, dz           HI/LO write pulse, divide-by-zero pulse
//   result             MFHI/MFLO read data (combinational)
//   hi, lo             architectural HI/LO registers
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       aluop,
  input  logic             sgn,
  input  logic [WIDTH-1:0] rA,
  input  logic [WIDTH-1:0] rB,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] MULT_OP = 6'b000010;
  localparam logic [5:0] DIV_OP  = 6'b000011;
  localparam logic [5:0] MFHI_OP = 6'b000100;
  localparam logic [5:0] MFLO_OP = 6'b000101;
  localparam int         CW      = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_acc;     // upper accumulator / partial remainder
  logic [WIDTH-1:0]   r_q;       // multiplier -> product low / dividend -> quotient
  logic [WIDTH-1:0]   r_b;       // multiplicand / divisor magnitude
  logic [CW-1:0]      r_count;
  logic               r_is_div, r_neg_q, r_neg_r, r_dz;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_dz_out;

  logic               w_op_md, w_op_any, w_accept, w_last;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_opa, w_opb, w_sum;
  logic               w_mul_end, w_mul_skip;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_quo, w_rem;

  assign w_op_md  = (aluop == MULT_OP) || (aluop == DIV_OP);
  assign w_op_any = w_op_md || (aluop == MFHI_OP) || (aluop == MFLO_OP);
  assign w_accept = start && (r_state == S_IDLE) && w_op_md;
  assign w_last   = (r_count == CW'(WIDTH - 1));
  assign w_abs_a  = (sgn && rA[WIDTH-1]) ? -rA : rA;
  assign w_abs_b  = (sgn && rB[WIDTH-1]) ? -rB : rB;

  // Single adder shared by both algorithms: add-if-LSB for MUL,
  // trial subtract of the divisor from the shifted remainder for DIV.
  always_comb begin
    w_opb = {1'b0, r_b};
    if (r_state == S_DIV) begin
      w_opa = {r_acc, r_q[WIDTH-1]};
      w_sum = w_opa - w_opb;
    end else begin
      w_opa = {1'b0, r_acc};
      w_sum = w_opa + (r_q[0] ? w_opb : '0);
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] w_live;
  logic [CW-1:0]    w_realign;
  // r_q[WIDTH-1-count:0] still holds unconsumed multiplier bits; bit 0 is
  // consumed this cycle, so only the bits above it decide another pass.
  assign w_live     = r_q & ({WIDTH{1'b1}} >> r_count);
  assign w_mul_end  = ((w_live >> 1) == '0);
  assign w_mul_skip = (w_abs_b == '0);
  // Stopping after count passes leaves the product WIDTH-count bits high.
  assign w_realign  = CW'(WIDTH) - r_count;
  assign w_prod     = {r_acc, r_q} >> w_realign;
`else
  assign w_mul_end  = w_last;
  assign w_mul_skip = 1'b0;
  assign w_prod     = {r_acc, r_q};
`endif

  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  // Divide by zero leaves the dividend magnitude in r_acc, so the signed
  // remainder path reproduces rA on hi; only lo needs forcing.
  assign w_quo    = r_dz ? '1 : (r_neg_q ? -r_q : r_q);
  assign w_rem    = r_neg_r ? -r_acc : r_acc;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (aluop == DIV_OP)  w_next = S_DIV;
          else if (w_mul_skip)  w_next = S_FIX;
          else                  w_next = S_MUL;
        end
      end
      S_MUL:   if (w_mul_end) w_next = S_FIX;
      S_DIV:   if (w_last)    w_next = S_FIX;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dz_out <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_done   <= 1'b0;
      r_dz_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div <= (aluop == DIV_OP);
            r_acc    <= '0;
            r_q      <= (aluop == DIV_OP) ? w_abs_a : w_abs_b;
            r_b      <= (aluop == DIV_OP) ? w_abs_b : w_abs_a;
            r_count  <= '0;
            r_neg_q  <= sgn && (rA[WIDTH-1] ^ rB[WIDTH-1]);
            r_neg_r  <= sgn && rA[WIDTH-1];
            r_dz     <= (aluop == DIV_OP) && (rB == '0);
          end
        end
        S_MUL: begin
          r_acc   <= w_sum[WIDTH:1];
          r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
          r_count <= r_count + 1'b1;
        end
        S_DIV: begin
          // Negative trial result means restore: keep the shifted remainder.
          r_acc   <= w_sum[WIDTH] ? w_opa[WIDTH-1:0] : w_sum[WIDTH-1:0];
          r_q     <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
          r_count <= r_count + 1'b1;
        end
        default: begin
          if (r_is_div) begin
            r_hi     <= w_rem;
            r_lo     <= w_quo;
            r_dz_out <= r_dz;
          end else begin
            {r_hi, r_lo} <= w_prod_s;
          end
          r_done <= 1'b1;
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign stall  = start && busy && w_op_any;
  assign done   = r_done;
  assign dz     = r_dz_out;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign result = (aluop == MFHI_OP) ? r_hi : ((aluop == MFLO_OP) ? r_lo : '0);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - Scoreboard testbench for muldiv_ctrl
module tb_muldiv_ctrl;
  localparam int W = 32;
  localparam logic [5:0] MULT_OP = 6'b000010;
  localparam logic [5:0] DIV_OP  = 6'b000011;
  localparam logic [5:0] MFHI_OP = 6'b000100;
  localparam logic [5:0] MFLO_OP = 6'b000101;
  localparam logic [5:0] OTHER_OP = 6'b100001;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   aluop = 6'd0;
  logic         sgn = 1'b0;
  logic [W-1:0] rA = '0;
  logic [W-1:0] rB = '0;
  logic         stall, busy, done, dz;
  logic [W-1:0] result, hi, lo;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .aluop(aluop), .sgn(sgn),
    .rA(rA), .rB(rB), .stall(stall), .busy(busy), .done(done), .dz(dz),
    .result(result), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;
  exp_t scb[$];

  // Reference state: values visible now depend on whether the last op finished.
  int          busy_until = 0;
  logic [31:0] prev_hi = 0, prev_lo = 0, pend_hi = 0, pend_lo = 0;

  function automatic bit model_busy();
    return cyc < busy_until;
  endfunction

  function automatic logic [31:0] model_hi();
    return model_busy() ? prev_hi : pend_hi;
  endfunction

  function automatic logic [31:0] model_lo();
    return model_busy() ? prev_lo : pend_lo;
  endfunction

  function automatic int latency(input logic [5:0] op, input logic s, input logic [31:0] b);
    if (op == MULT_OP) begin
`ifdef MULDIV_EARLY_OUT_EN
      logic [31:0] m;
      m = (s && b[31]) ? -b : b;
      if (m == 0) return 2;
      for (int k = 31; k >= 0; k--) if (m[k]) return 3 + k;
`else
      if (s) return W + 2;
`endif
    end
    return W + 2;
  endfunction

  task automatic accept_op(input logic [5:0] op, input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sa, sbv, sp, sq, sr;
    logic [63:0] up;
    e.dz = 1'b0;
    if (op == MULT_OP) begin
      if (s) begin
        sa = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        sp = sa * sbv;
        up = sp;
      end else begin
        up = {32'd0, a} * {32'd0, b};
      end
      e.hi = up[63:32];
      e.lo = up[31:0];
    end else if (b == 0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
    end else if (s) begin
      sa = {{32{a[31]}}, a};
      sbv = {{32{b[31]}}, b};
      sq = sa / sbv;
      sr = sa % sbv;
      e.lo = sq[31:0];
      e.hi = sr[31:0];
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    e.cyc = cyc + latency(op, s, b);
    scb.push_back(e);
    prev_hi = pend_hi;
    prev_lo = pend_lo;
    pend_hi = e.hi;
    pend_lo = e.lo;
    busy_until = e.cyc;
  endtask

  // Presents a request (driven at posedge+1) until the interlock lets it through.
  task automatic present(input logic [5:0] op, input logic s, input logic [31:0] a, input logic [31:0] b);
    bit taken = 0;
    bit exp_stall;
    int guard = 0;
    start = 1'b1; aluop = op; sgn = s; rA = a; rB = b;
    while (!taken) begin
      @(negedge clock);
      exp_stall = model_busy() && (op inside {MULT_OP, DIV_OP, MFHI_OP, MFLO_OP});
      chk("stall", 64'(stall), 64'(exp_stall));
      if (!exp_stall) begin
        if (op == MFHI_OP) chk("mfhi_result", 64'(result), 64'(model_hi()));
        if (op == MFLO_OP) chk("mflo_result", 64'(result), 64'(model_lo()));
        if (op == MULT_OP || op == DIV_OP) accept_op(op, s, a, b);
        taken = 1;
      end
      @(posedge clock); #1;
      guard++;
      if (!taken && guard > 200) begin
        chk("present_timeout", 64'd1, 64'd0);
        taken = 1;
      end
    end
    start = 1'b0; aluop = 6'd0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (model_busy() && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n) begin
      if (done) begin
        if (scb.size() == 0) begin
          chk("done_unexpected", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = scb.pop_front();
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("dz", 64'(dz), 64'(e.dz));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        chk("dz_without_done", 64'(dz), 64'd0);
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Directed cases
    present(MULT_OP, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    present(MFHI_OP, 1'b0, 0, 0);
    present(MFLO_OP, 1'b0, 0, 0);
    present(DIV_OP, 1'b1, 32'hFFFF_FFF9, 32'd2);
    present(MFLO_OP, 1'b0, 0, 0);
    present(DIV_OP, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    present(DIV_OP, 1'b0, 32'h1234, 32'd0);
    present(DIV_OP, 1'b1, 32'hFFFF_0000, 32'd0);
    present(MULT_OP, 1'b1, 32'd3, 32'd5);
    present(OTHER_OP, 1'b0, 0, 0);
    present(MFLO_OP, 1'b0, 0, 0);
    present(MULT_OP, 1'b0, 32'd7, 32'd1);
    present(DIV_OP, 1'b1, 32'd100, 32'hFFFF_FFF9);
    present(MULT_OP, 1'b0, 32'd1, 32'h8000_0000);
    present(MFHI_OP, 1'b0, 0, 0);

    // Reset in the middle of a divide
    present(DIV_OP, 1'b1, 32'h7654_3210, 32'd3);
    repeat (10) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    scb.delete();
    busy_until = 0;
    prev_hi = 0; prev_lo = 0; pend_hi = 0; pend_lo = 0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    present(MULT_OP, 1'b1, 32'd2, 32'd2);
    present(MFLO_OP, 1'b0, 0, 0);

    // Randomized traffic, mixing back-to-back requests and HI/LO reads
    for (int i = 0; i < 40; i++) begin
      logic [5:0] op;
      op = $urandom_range(0, 1) ? MULT_OP : DIV_OP;
      present(op, 1'($urandom_range(0, 1)), pick(), pick());
      case ($urandom_range(0, 3))
        0: present(MFHI_OP, 1'b0, 0, 0);
        1: present(MFLO_OP, 1'b0, 0, 0);
        2: ;
        default: begin
          wait_idle();
          repeat ($urandom_range(0, 2)) begin
            @(posedge clock); #1;
          end
        end
      endcase
    end

    wait_idle();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("scoreboard_drained", 64'(scb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
